hazard_ctrl: RTL and testbench

Pipeline hazard controller for the 5-stage RISC-V core, sitting beside the forwarding unit. Hazards that forwarding cannot cover are resolved here. Load-use dependences insert LOAD_LAT bubbles, taken branches and jumps squash wrong-path instructions, and a data-memory wait freezes the whole pipe. It also keeps saturating stall and flush counters and a sticky memory-timeout flag.

---
 rtl/hazard_ctrl_if.sv | 39 +++
 rtl/hazard_ctrl.sv | 127 ++++++++++++
 tb/tb_hazard_ctrl.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_if.sv
// Hazard-controller signal bundle: pipeline hazard inputs toward the controller,
// stall/flush/bubble controls and status back to the pipeline.
interface hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
) ();
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_use_rs1;
  logic             id_use_rs2;
  logic [4:0]       ex_rd;
  logic             ex_MemRead;
  logic             ex_BrTaken;
  logic             mem_req;
  logic             mem_ready;
  logic             pc_stall;
  logic             ifid_stall;
  logic             idex_stall;
  logic             exmem_stall;
  logic             ifid_flush;
  logic             idex_flush;
  logic             memwb_bubble;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic             mem_timeout;

  modport master (
    output id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_MemRead,
           ex_BrTaken, mem_req, mem_ready,
    input  pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush,
           idex_flush, memwb_bubble, stall_cnt, flush_cnt, mem_timeout
  );

  modport slave (
    input  id_rs1, id_rs2, id_use_rs1, id_use_rs2, ex_rd, ex_MemRead,
           ex_BrTaken, mem_req, mem_ready,
    output pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush,
           idex_flush, memwb_bubble, stall_cnt, flush_cnt, mem_timeout
  );
endinterface

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use bubbles, taken-branch squash,
// data-memory freeze, saturating stall/flush counters and sticky memory timeout.
module hazard_ctrl #(
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned WAIT_MAX = 255,
  parameter int unsigned CNT_W    = 16
) (
  input logic          clk,
  input logic          rst,
  hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {RUN, LDSTALL, MWAIT} state_e;

  localparam logic [2:0]  LD_INIT = 3'(LOAD_LAT - 1);
  localparam logic [15:0] WMAX    = 16'(WAIT_MAX);

  state_e           state_q, state_d;
  state_e           ret_q, ret_d;
  state_e           eff;
  logic [2:0]       ld_cnt_q, ld_cnt_d;
  logic [15:0]      wait_q, wait_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;

  logic freeze, hazard;
  logic pc_st, ifid_st, idex_st, exmem_st, ifid_fl, idex_fl, wb_bub;

  assign freeze = hz.mem_req & ~hz.mem_ready;
  assign hazard = hz.ex_MemRead && (hz.ex_rd != '0) &&
                  ((hz.id_use_rs1 && (hz.id_rs1 == hz.ex_rd)) ||
                   (hz.id_use_rs2 && (hz.id_rs2 == hz.ex_rd)));
  // Leaving MWAIT, the release cycle acts as the state that was interrupted.
  assign eff = (state_q == MWAIT) ? ret_q : state_q;

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    ld_cnt_d  = ld_cnt_q;
    wait_d    = wait_q;
    timeout_d = timeout_q;
    pc_st     = 1'b0;
    ifid_st   = 1'b0;
    idex_st   = 1'b0;
    exmem_st  = 1'b0;
    ifid_fl   = 1'b0;
    idex_fl   = 1'b0;
    wb_bub    = 1'b0;
    if (freeze) begin
      pc_st    = 1'b1;
      ifid_st  = 1'b1;
      idex_st  = 1'b1;
      exmem_st = 1'b1;
      wb_bub   = 1'b1;
      if (state_q != MWAIT) begin
        ret_d   = state_q;
        state_d = MWAIT;
        wait_d  = 16'd1;
      end else if (wait_q < WMAX) begin
        wait_d = wait_q + 16'd1;
      end
      if (wait_d == WMAX) timeout_d = 1'b1;
    end else begin
      wait_d = '0;
      if (hz.ex_BrTaken) begin
        ifid_fl  = 1'b1;
        idex_fl  = 1'b1;
        ld_cnt_d = '0;
        state_d  = RUN;
      end else if (eff == LDSTALL) begin
        pc_st    = 1'b1;
        ifid_st  = 1'b1;
        idex_fl  = 1'b1;
        ld_cnt_d = ld_cnt_q - 3'd1;
        state_d  = (ld_cnt_q == 3'd1) ? RUN : LDSTALL;
      end else if (hazard) begin
        pc_st   = 1'b1;
        ifid_st = 1'b1;
        idex_fl = 1'b1;
        if (LOAD_LAT > 1) begin
          state_d  = LDSTALL;
          ld_cnt_d = LD_INIT;
        end else begin
          state_d = RUN;
        end
      end else begin
        state_d = RUN;
      end
    end
    stall_d = (pc_st && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;
    flush_d = (ifid_fl && (flush_q != '1)) ? flush_q + 1'b1 : flush_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= RUN;
      ret_q     <= RUN;
      ld_cnt_q  <= '0;
      wait_q    <= '0;
      timeout_q <= 1'b0;
      stall_q   <= '0;
      flush_q   <= '0;
    end else begin
      state_q   <= state_d;
      ret_q     <= ret_d;
      ld_cnt_q  <= ld_cnt_d;
      wait_q    <= wait_d;
      timeout_q <= timeout_d;
      stall_q   <= stall_d;
      flush_q   <= flush_d;
    end
  end

  // Controls are forced low while reset is held so an abort is seen at once.
  assign hz.pc_stall     = pc_st & ~rst;
  assign hz.ifid_stall   = ifid_st & ~rst;
  assign hz.idex_stall   = idex_st & ~rst;
  assign hz.exmem_stall  = exmem_st & ~rst;
  assign hz.ifid_flush   = ifid_fl & ~rst;
  assign hz.idex_flush   = idex_fl & ~rst;
  assign hz.memwb_bubble = wb_bub & ~rst;
  assign hz.stall_cnt    = stall_q;
  assign hz.flush_cnt    = flush_q;
  assign hz.mem_timeout  = timeout_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: two instances (LOAD_LAT=3/WAIT_MAX=3/16-bit
// counters and LOAD_LAT=1/WAIT_MAX=5/4-bit counters) against a bubble-count model.
module tb_hazard_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [4:0] rs1, rs2, rd;
  logic       u1, u2, mrd, br, mreq, mrdy;

  hazard_ctrl_if #(.CNT_W(16)) hif_a ();
  hazard_ctrl_if #(.CNT_W(4))  hif_b ();

  assign hif_a.id_rs1 = rs1;  assign hif_b.id_rs1 = rs1;
  assign hif_a.id_rs2 = rs2;  assign hif_b.id_rs2 = rs2;
  assign hif_a.id_use_rs1 = u1;  assign hif_b.id_use_rs1 = u1;
  assign hif_a.id_use_rs2 = u2;  assign hif_b.id_use_rs2 = u2;
  assign hif_a.ex_rd = rd;  assign hif_b.ex_rd = rd;
  assign hif_a.ex_MemRead = mrd;  assign hif_b.ex_MemRead = mrd;
  assign hif_a.ex_BrTaken = br;  assign hif_b.ex_BrTaken = br;
  assign hif_a.mem_req = mreq;  assign hif_b.mem_req = mreq;
  assign hif_a.mem_ready = mrdy;  assign hif_b.mem_ready = mrdy;

  hazard_ctrl #(.LOAD_LAT(3), .WAIT_MAX(3), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .hz(hif_a)
  );
  hazard_ctrl #(.LOAD_LAT(1), .WAIT_MAX(5), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .hz(hif_b)
  );

  logic [6:0]  ctl  [2];
  logic [15:0] sc_o [2];
  logic [15:0] fc_o [2];
  logic        to_o [2];

  assign ctl[0] = {hif_a.pc_stall, hif_a.ifid_stall, hif_a.idex_stall, hif_a.exmem_stall,
                   hif_a.ifid_flush, hif_a.idex_flush, hif_a.memwb_bubble};
  assign ctl[1] = {hif_b.pc_stall, hif_b.ifid_stall, hif_b.idex_stall, hif_b.exmem_stall,
                   hif_b.ifid_flush, hif_b.idex_flush, hif_b.memwb_bubble};
  assign sc_o[0] = hif_a.stall_cnt;
  assign sc_o[1] = {12'd0, hif_b.stall_cnt};
  assign fc_o[0] = hif_a.flush_cnt;
  assign fc_o[1] = {12'd0, hif_b.flush_cnt};
  assign to_o[0] = hif_a.mem_timeout;
  assign to_o[1] = hif_b.mem_timeout;

  // Reference model: remaining bubbles, current wait length, counters.
  int lat_p [2] = '{3, 1};
  int wmx_p [2] = '{3, 5};
  int cmx_p [2] = '{65535, 15};
  int m_bub [2];
  int m_wl  [2];
  int m_sc  [2];
  int m_fc  [2];
  bit m_to  [2];

  int n_chk = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_bub[i] = 0; m_wl[i] = 0; m_sc[i] = 0; m_fc[i] = 0; m_to[i] = 1'b0;
    end
  endtask

  task automatic quiet();
    rs1 = '0; rs2 = '0; rd = '0; u1 = 1'b0; u2 = 1'b0;
    mrd = 1'b0; br = 1'b0; mreq = 1'b0; mrdy = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("%s_ctrl%0d", tag, i), {25'd0, ctl[i]}, 32'd0);
      check_eq($sformatf("%s_stall_cnt%0d", tag, i), {16'd0, sc_o[i]}, 32'd0);
      check_eq($sformatf("%s_flush_cnt%0d", tag, i), {16'd0, fc_o[i]}, 32'd0);
      check_eq($sformatf("%s_timeout%0d", tag, i), {31'd0, to_o[i]}, 32'd0);
    end
  endtask

  // Called at a negedge with inputs set; checks this cycle, advances the model.
  task automatic cycle();
    logic       frz, haz;
    logic [6:0] e;
    #1;
    frz = mreq & ~mrdy;
    haz = mrd && (rd != 5'd0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    for (int i = 0; i < 2; i++) begin
      if (frz)                      e = 7'b1111001;
      else if (br)                  e = 7'b0000110;
      else if (m_bub[i] > 0 || haz) e = 7'b1100010;
      else                          e = 7'b0000000;
      check_eq($sformatf("ctrl%0d", i), {25'd0, ctl[i]}, {25'd0, e});
      check_eq($sformatf("stall_cnt%0d", i), {16'd0, sc_o[i]}, m_sc[i]);
      check_eq($sformatf("flush_cnt%0d", i), {16'd0, fc_o[i]}, m_fc[i]);
      check_eq($sformatf("timeout%0d", i), {31'd0, to_o[i]}, {31'd0, m_to[i]});
      if (frz) begin
        if (m_wl[i] < wmx_p[i]) m_wl[i]++;
        if (m_wl[i] >= wmx_p[i]) m_to[i] = 1'b1;
      end else begin
        m_wl[i] = 0;
        if (br)                m_bub[i] = 0;
        else if (m_bub[i] > 0) m_bub[i]--;
        else if (haz)          m_bub[i] = lat_p[i] - 1;
      end
      if (e[6] && m_sc[i] < cmx_p[i]) m_sc[i]++;
      if (e[2] && m_fc[i] < cmx_p[i]) m_fc[i]++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    quiet();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cycle();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    quiet();
    model_reset();
    @(negedge clk);
    @(negedge clk);
    #1;
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    cycle();

    // load-use on rs1
    quiet(); mrd = 1'b1; rd = 5'd5; rs1 = 5'd5; u1 = 1'b1; cycle();
    quiet(); repeat (4) cycle();

    // load-use on rs2; then rs2 not used; then ex_rd = 0
    quiet(); mrd = 1'b1; rd = 5'd7; rs2 = 5'd7; u2 = 1'b1; cycle();
    quiet(); repeat (4) cycle();
    mrd = 1'b1; rd = 5'd7; rs2 = 5'd7; u2 = 1'b0; cycle();
    quiet(); cycle();
    mrd = 1'b1; rd = 5'd0; rs1 = 5'd0; u1 = 1'b1; rs2 = 5'd0; u2 = 1'b1; cycle();
    quiet(); cycle();

    // taken branch with a simultaneous load match
    br = 1'b1; mrd = 1'b1; rd = 5'd5; rs1 = 5'd5; u1 = 1'b1; cycle();
    quiet(); repeat (3) cycle();

    // 4-cycle memory wait
    mreq = 1'b1; mrdy = 1'b0; repeat (4) cycle();
    mrdy = 1'b1; cycle();
    quiet(); repeat (2) cycle();

    // freeze inside the bubble countdown
    mrd = 1'b1; rd = 5'd9; rs1 = 5'd9; u1 = 1'b1; cycle();
    quiet(); mreq = 1'b1; mrdy = 1'b0; repeat (2) cycle();
    mrdy = 1'b1; cycle();
    quiet(); repeat (4) cycle();

    // long wait reaching the timeout, then release
    mreq = 1'b1; mrdy = 1'b0; repeat (5) cycle();
    mrdy = 1'b1; cycle();
    quiet(); repeat (2) cycle();

    // async reset in the middle of a wait and of a load stall
    mreq = 1'b1; mrdy = 1'b0; repeat (2) cycle();
    #3 rst = 1'b1;
    #1 check_all_zero("midwait_rst");
    model_reset();
    quiet();
    @(negedge clk);
    rst = 1'b0;
    cycle();
    mrd = 1'b1; rd = 5'd3; rs2 = 5'd3; u2 = 1'b1; cycle();
    quiet();
    #3 rst = 1'b1;
    #1 check_all_zero("midld_rst");
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cycle();

    // randomized traffic
    for (int n = 0; n < 2000; n++) begin
      rs1  = 5'($urandom_range(0, 3));
      rs2  = 5'($urandom_range(0, 3));
      rd   = 5'($urandom_range(0, 3));
      u1   = 1'($urandom_range(0, 1));
      u2   = 1'($urandom_range(0, 1));
      mrd  = ($urandom_range(0, 2) == 0);
      br   = ($urandom_range(0, 7) == 0);
      mreq = ($urandom_range(0, 3) == 0);
      mrdy = ($urandom_range(0, 2) == 0);
      cycle();
      if (n == 1000) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
